// File: rtl/tamper_monitor.sv
// Tamper monitor: per-sensor 2-flop sync, debounce, sticky alarm FSM with minimum hold and coded clear.
// Optional active-mesh integrity check is built when TAMPER_MESH_CHECK_EN is defined.
`timescale 1ns/1ps
module tamper_monitor #(
  parameter int          NUM_SENSORS     = 4,
  parameter int          DEBOUNCE_CYCLES = 8,
  parameter int          HOLD_CYCLES     = 16,
  parameter logic [31:0] CLEAR_CODE      = 32'hC1EA_0000
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_SENSORS-1:0] sensor_in,
  input  logic [NUM_SENSORS-1:0] sensor_mask,
  input  logic                   clear_req,
  input  logic [31:0]            clear_code,
  output logic                   tamper_detected,
  output logic [NUM_SENSORS:0]   tamper_cause,
  output logic [7:0]             tamper_count,
  output logic                   clear_reject
`ifdef TAMPER_MESH_CHECK_EN
  ,
  output logic [7:0]             mesh_out,
  input  logic [7:0]             mesh_in
`endif
);

  localparam int NCH = NUM_SENSORS + 1;
  localparam int DW  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int HW  = $clog2(HOLD_CYCLES + 1);
  localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD_CYCLES);

  typedef enum logic {ST_ARMED = 1'b0, ST_ALARM = 1'b1} state_t;

  logic [NUM_SENSORS-1:0] r_s1, r_s2, r_mask_prev;
  logic                   w_mesh_fault;
  logic [NCH-1:0]         w_level, w_mask_chg, w_trip;
  logic                   w_any_trip, w_clear_ok;

  state_t         r_state, w_state_next;
  logic [HW-1:0]  r_hold, w_hold_next;
  logic [NCH-1:0] r_cause, w_cause_next;
  logic [7:0]     r_count, w_count_next;
  logic           r_reject, w_reject_next;
  logic           r_detected;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_s1        <= '0;
      r_s2        <= '0;
      r_mask_prev <= '0;
    end else begin
      r_s1        <= sensor_in;
      r_s2        <= r_s1;
      r_mask_prev <= sensor_mask;
    end
  end

`ifdef TAMPER_MESH_CHECK_EN
  logic [7:0] r_lfsr, r_ref_d1, r_ref_d2, r_mesh_s1, r_mesh_s2;
  logic [1:0] r_warm;

  // Reference is mesh_out delayed to line up with the return path through the sync pair.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_lfsr    <= 8'hA5;
      r_ref_d1  <= '0;
      r_ref_d2  <= '0;
      r_mesh_s1 <= '0;
      r_mesh_s2 <= '0;
      r_warm    <= '0;
    end else begin
      r_lfsr    <= {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};
      r_ref_d1  <= r_lfsr;
      r_ref_d2  <= r_ref_d1;
      r_mesh_s1 <= mesh_in;
      r_mesh_s2 <= r_mesh_s1;
      if (r_warm != 2'd3) r_warm <= r_warm + 2'd1;
    end
  end

  assign mesh_out     = r_lfsr;
  assign w_mesh_fault = (r_warm == 2'd3) && (r_mesh_s2 != r_ref_d2);
`else
  assign w_mesh_fault = 1'b0;
`endif

  // The mesh channel sits on the top bit and cannot be masked.
  assign w_level    = {w_mesh_fault, r_s2 & ~sensor_mask};
  assign w_mask_chg = {1'b0, sensor_mask ^ r_mask_prev};
  assign w_any_trip = |w_trip;
  assign w_clear_ok = clear_req && (r_state == ST_ALARM) && (clear_code == CLEAR_CODE) &&
                      (r_hold == '0) && (w_level == '0) && !w_any_trip;

  genvar gi;
  generate
    for (gi = 0; gi < NCH; gi++) begin : g_db
      logic [DW-1:0] r_cnt;

      assign w_trip[gi] = w_level[gi] && !w_mask_chg[gi] && (r_cnt == DB_LAST);

      always_ff @(posedge clk) begin
        if (reset || w_clear_ok || w_mask_chg[gi] || !w_level[gi]) begin
          r_cnt <= '0;
        end else if (r_cnt != DB_LAST) begin
          r_cnt <= r_cnt + 1'b1;
        end
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_ARMED;
      r_hold     <= '0;
      r_cause    <= '0;
      r_count    <= '0;
      r_reject   <= 1'b0;
      r_detected <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_hold     <= w_hold_next;
      r_cause    <= w_cause_next;
      r_count    <= w_count_next;
      r_reject   <= w_reject_next;
      r_detected <= (w_state_next == ST_ALARM);
    end
  end

  // A trip outranks a clear in the same cycle; the clear is then refused.
  always_comb begin
    w_state_next  = r_state;
    w_hold_next   = r_hold;
    w_cause_next  = r_cause;
    w_count_next  = r_count;
    w_reject_next = clear_req && !w_clear_ok;
    if (w_clear_ok) begin
      w_state_next = ST_ARMED;
      w_cause_next = '0;
    end else if (w_any_trip) begin
      w_state_next = ST_ALARM;
      w_hold_next  = HOLD_LOAD;
      w_cause_next = r_cause | w_trip;
      if ((r_state == ST_ARMED) && (r_count != 8'hFF)) w_count_next = r_count + 8'd1;
    end else if ((r_state == ST_ALARM) && (r_hold != '0)) begin
      w_hold_next = r_hold - 1'b1;
    end
  end

  assign tamper_detected = r_detected;
  assign tamper_cause    = r_cause;
  assign tamper_count    = r_count;
  assign clear_reject    = r_reject;

endmodule

// File: tb/tb_tamper_monitor.sv
// Bench for tamper_monitor: directed scenarios plus random traffic, scored per cycle against a reference model.
`timescale 1ns/1ps
module tb_tamper_monitor;

  localparam int          NS   = 4;
  localparam int          DB   = 8;
  localparam int          HOLD = 16;
  localparam logic [31:0] CC   = 32'hC1EA_0000;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [NS-1:0] sensor_in = '0;
  logic [NS-1:0] sensor_mask = '0;
  logic          clear_req = 1'b0;
  logic [31:0]   clear_code = '0;
  logic          tamper_detected;
  logic [NS:0]   tamper_cause;
  logic [7:0]    tamper_count;
  logic          clear_reject;

  tamper_monitor #(
    .NUM_SENSORS(NS), .DEBOUNCE_CYCLES(DB), .HOLD_CYCLES(HOLD), .CLEAR_CODE(CC)
  ) dut (
    .clk(clk), .reset(reset), .sensor_in(sensor_in), .sensor_mask(sensor_mask),
    .clear_req(clear_req), .clear_code(clear_code), .tamper_detected(tamper_detected),
    .tamper_cause(tamper_cause), .tamper_count(tamper_count), .clear_reject(clear_reject)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        det;
    logic [NS:0] cause;
    logic [7:0]  count;
    logic        rej;
  } obs_t;

  obs_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  bit   quiet  = 1'b0;
  int   cyc    = 0;

  // Reference model: sensor history as a delay line, debounce as run lengths,
  // hold expressed as "edges since last (re)load of the alarm".
  logic [NS-1:0] m_h1, m_h2, m_prev_mask;
  int            m_run [NS];
  bit            m_alarm, m_rej;
  logic [NS:0]   m_cause;
  logic [7:0]    m_count;
  int            m_edge, m_last_load;

  task automatic model_step(input logic [NS-1:0] s, input logic [NS-1:0] m,
                            input logic cr, input logic [31:0] code, input logic rs);
    logic [NS-1:0] eff, trip, chg;
    bit expired, accept;
    m_edge++;
    if (rs) begin
      m_h1 = '0; m_h2 = '0; m_prev_mask = '0;
      for (int i = 0; i < NS; i++) m_run[i] = 0;
      m_alarm = 0; m_rej = 0; m_cause = '0; m_count = '0; m_last_load = m_edge;
    end else begin
      eff  = m_h2 & ~m;
      chg  = m ^ m_prev_mask;
      trip = '0;
      for (int i = 0; i < NS; i++)
        if (eff[i] && !chg[i] && m_run[i] >= DB - 1) trip[i] = 1'b1;
      expired = (m_edge - m_last_load) > HOLD;
      accept  = cr && m_alarm && (code == CC) && expired && (eff == '0) && (trip == '0);
      m_rej   = cr && !accept;
      for (int i = 0; i < NS; i++)
        m_run[i] = (accept || chg[i] || !eff[i]) ? 0 : m_run[i] + 1;
      if (accept) begin
        m_alarm = 0;
        m_cause = '0;
      end else if (trip != '0) begin
        if (!m_alarm) begin
          m_alarm = 1;
          if (m_count != 8'hFF) m_count = m_count + 8'd1;
        end
        m_cause     = m_cause | {1'b0, trip};
        m_last_load = m_edge;
      end
      m_prev_mask = m;
      m_h2 = m_h1;
      m_h1 = s;
    end
  endtask

  task automatic tick(input logic [NS-1:0] s, input logic [NS-1:0] m,
                      input logic cr, input logic [31:0] code, input logic rs);
    obs_t e;
    sensor_in = s; sensor_mask = m; clear_req = cr; clear_code = code; reset = rs;
    @(posedge clk);
    model_step(s, m, cr, code, rs);
    e = {m_alarm, m_cause, m_count, m_rej};
    exp_q.push_back(e);
    @(negedge clk);
  endtask

  task automatic idle(input int n, input logic [NS-1:0] m);
    for (int k = 0; k < n; k++) tick('0, m, 1'b0, 32'h0, 1'b0);
  endtask

  task automatic expect_eq(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", name, got, want);
    end else begin
      $display("check %s = %0h", name, got);
    end
  endtask

  // Monitor: one expected observation per clock; compared on the falling edge.
  obs_t last_seen = '0;
  always @(negedge clk) begin : mon
    obs_t e, a;
    cyc++;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = {tamper_detected, tamper_cause, tamper_count, clear_reject};
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL scoreboard cyc=%0d got det=%0b cause=%b count=%0d rej=%0b want det=%0b cause=%b count=%0d rej=%0b",
                 cyc, a.det, a.cause, a.count, a.rej, e.det, e.cause, e.count, e.rej);
      end else if (!quiet && e != last_seen) begin
        $display("txn cyc=%0d det=%0b cause=%b count=%0d rej=%0b", cyc, e.det, e.cause, e.count, e.rej);
      end
      last_seen = e;
    end
  end

  initial begin : watchdog
    #5_000_000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin : drive
    logic [NS-1:0] rnd_s, cur_mask;
    int            len [NS];
    logic          cr;
    logic [31:0]   code;
    logic          rs;
    m_edge = 0;
    rnd_s = '0; cur_mask = '0;
    for (int i = 0; i < NS; i++) len[i] = 0;

    repeat (3) tick('0, '0, 1'b0, 32'h0, 1'b1);
    expect_eq("reset_det",   tamper_detected, 0);
    expect_eq("reset_cause", tamper_cause, 0);
    expect_eq("reset_count", tamper_count, 0);
    expect_eq("reset_rej",   clear_reject, 0);

    // Pulse of 7 synced cycles must not trip.
    repeat (7) tick(4'b0010, '0, 1'b0, 32'h0, 1'b0);
    idle(12, '0);
    expect_eq("short_pulse_det",   tamper_detected, 0);
    expect_eq("short_pulse_count", tamper_count, 0);

    // Held sensor trips on the 10th edge.
    repeat (9) tick(4'b0001, '0, 1'b0, 32'h0, 1'b0);
    expect_eq("latency_e9_det", tamper_detected, 0);
    tick(4'b0001, '0, 1'b0, 32'h0, 1'b0);
    expect_eq("latency_e10_det",   tamper_detected, 1);
    expect_eq("latency_e10_cause", tamper_cause, 5'b00001);
    expect_eq("latency_e10_count", tamper_count, 1);

    // Clear during hold is refused; retry after hold is accepted.
    idle(4, '0);
    tick('0, '0, 1'b1, CC, 1'b0);
    expect_eq("early_clear_rej", clear_reject, 1);
    expect_eq("early_clear_det", tamper_detected, 1);
    idle(16, '0);
    tick('0, '0, 1'b1, CC, 1'b0);
    expect_eq("clear_det",   tamper_detected, 0);
    expect_eq("clear_cause", tamper_cause, 0);
    expect_eq("clear_count", tamper_count, 1);
    expect_eq("clear_rej",   clear_reject, 0);
    tick('0, '0, 1'b1, CC, 1'b0);
    expect_eq("armed_clear_rej", clear_reject, 1);

    // Wrong code, then trip coinciding with a valid clear.
    repeat (10) tick(4'b0001, '0, 1'b0, 32'h0, 1'b0);
    idle(20, '0);
    tick('0, '0, 1'b1, 32'hDEAD_BEEF, 1'b0);
    expect_eq("bad_code_rej", clear_reject, 1);
    expect_eq("bad_code_det", tamper_detected, 1);
    repeat (9) tick(4'b0100, '0, 1'b0, 32'h0, 1'b0);
    tick(4'b0100, '0, 1'b1, CC, 1'b0);
    expect_eq("trip_vs_clear_rej",   clear_reject, 1);
    expect_eq("trip_vs_clear_det",   tamper_detected, 1);
    expect_eq("trip_vs_clear_cause", tamper_cause, 5'b00101);
    expect_eq("trip_vs_clear_count", tamper_count, 2);
    idle(2, '0);
    tick('0, '0, 1'b1, CC, 1'b0);
    expect_eq("hold_reload_rej", clear_reject, 1);
    idle(20, '0);
    tick('0, '0, 1'b1, CC, 1'b0);
    expect_eq("clear2_det", tamper_detected, 0);

    // Masked sensor never trips; unmasking restarts the debounce.
    repeat (100) tick(4'b1000, 4'b1000, 1'b0, 32'h0, 1'b0);
    expect_eq("masked_det",   tamper_detected, 0);
    expect_eq("masked_count", tamper_count, 2);
    repeat (8) tick(4'b1000, '0, 1'b0, 32'h0, 1'b0);
    expect_eq("unmask_e8_det", tamper_detected, 0);
    tick(4'b1000, '0, 1'b0, 32'h0, 1'b0);
    expect_eq("unmask_e9_det",   tamper_detected, 1);
    expect_eq("unmask_e9_cause", tamper_cause, 5'b01000);
    expect_eq("unmask_e9_count", tamper_count, 3);
    idle(20, '0);
    tick('0, '0, 1'b1, CC, 1'b0);

    // Random traffic.
    for (int t = 0; t < 2000; t++) begin
      for (int i = 0; i < NS; i++) begin
        if (len[i] == 0) begin
          rnd_s[i] = ($urandom_range(0, 2) == 0);
          len[i]   = rnd_s[i] ? $urandom_range(1, 14) : $urandom_range(1, 40);
        end else begin
          len[i] = len[i] - 1;
        end
      end
      if ($urandom_range(0, 199) == 0) cur_mask = NS'($urandom);
      cr   = ($urandom_range(0, 11) == 0);
      code = ($urandom_range(0, 3) == 0) ? $urandom : CC;
      rs   = ($urandom_range(0, 999) == 0);
      tick(rnd_s, cur_mask, cr, code, rs);
    end

    // Repeated trip/clear to saturate the event counter.
    quiet = 1'b1;
    for (int n = 0; n < 300; n++) begin
      repeat (10) tick(4'b0001, '0, 1'b0, 32'h0, 1'b0);
      idle(20, '0);
      tick('0, '0, 1'b1, CC, 1'b0);
      idle(1, '0);
    end
    quiet = 1'b0;
    expect_eq("saturate_count", tamper_count, 255);
    expect_eq("saturate_det",   tamper_detected, 0);

    // Reset while in alarm.
    repeat (10) tick(4'b0001, '0, 1'b0, 32'h0, 1'b0);
    expect_eq("pre_reset_det", tamper_detected, 1);
    tick(4'b0001, '0, 1'b0, 32'h0, 1'b1);
    expect_eq("mid_reset_det",   tamper_detected, 0);
    expect_eq("mid_reset_cause", tamper_cause, 0);
    expect_eq("mid_reset_count", tamper_count, 0);
    expect_eq("mid_reset_rej",   clear_reject, 0);
    idle(3, '0);

    repeat (3) @(posedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain got=%0d want=0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
